cos_mul_sub_pipe: RTL and testbench
===================================

// Module: cos_mul_sub_pipe
// PURPOSE
//   Parametrised successor of the fixed 12x7 cosine multiply-subtract stage in the noise generator.
//   Computes p = {c_sign, c_mag -/+ ((a*b) >>> SHIFT)} as a 3-stage pipeline with valid/ready flow control.
//   Selects subtract or add per sample, for piecewise-polynomial segments whose coefficient sign varies.
//   Sits between the segment-coefficient ROM and the Box-Muller output combiner.
// PARAMETERS
//   A_W    7   signed width of a (polynomial argument)
//   B_W    12  signed width of b (coefficient)
//   C_W    19  width of c; bit C_W-1 is the quadrant sign flag, bits C_W-2:0 are the signed addend c_mag
//   P_W    16  width of p; bit P_W-1 carries the sign flag, bits P_W-2:0 hold the signed sum
//   SHIFT  0   arithmetic right shift applied to the product before the add/sub (LSBs dropped, truncated)
// PORTS
//   clock      in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      input sample valid
//   in_ready   out  1      block accepts a sample this cycle
//   in_a       in   A_W    signed multiplicand
//   in_b       in   B_W    signed multiplier
//   in_c       in   C_W    {sign flag, signed c_mag}
//   in_sub     in   1      1: c_mag - prod; 0: c_mag + prod
//   out_valid  out  1      out_p valid
//   out_ready  in   1      downstream accepts out_p
//   out_p      out  P_W    {sign flag, sum[P_W-2:0]}
//   out_ovf    out  1      sum exceeded the P_W-1-bit signed range (qualified by out_valid)
// BEHAVIOUR
//   - Reset (async assert, sync deassert done upstream): all valid bits, out_p, out_ovf = 0; in-flight samples dropped.
//   - Stages: S1 registers a, b, c_mag, c_sign, sub. S2 forms prod = a*b (A_W+B_W bits, signed).
//     S3 forms sum and drives out_p, out_ovf, out_valid.
//   - Latency 3 cycles from accepted input to out_valid; throughput 1 sample per cycle.
//   - stall = out_valid & ~out_ready; in_ready = ~stall. While stalled, every stage holds, with no loss or duplication.
//   - An empty (invalid) stage does not stall: bubbles collapse; a valid stage advances into an invalid slot.
//   - Sample accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
//   - Arithmetic: SUM_W = max(C_W-1, A_W+B_W-SHIFT) + 1. Sign-extend both operands to SUM_W, then add or subtract exactly.
//   - c_sign is passed through unchanged alongside the data: out_p[P_W-1] = c_sign of the same sample.
//   - Simultaneous accept and consume in the same cycle is legal and keeps the pipeline full.
//   - Reset asserted mid-stall: outputs go to 0 immediately; the first output after reset is the first sample accepted after reset.
// CONFIGURATION
//   COS_MUL_SAT_EN defined: if sum is outside [-2^(P_W-2), 2^(P_W-2)-1], clamp to the nearest bound and set out_ovf=1.
//   COS_MUL_SAT_EN undefined: out_p[P_W-2:0] = sum[P_W-2:0] (wrap); out_ovf still reports range violation.
// STRUCTURE
//   - Package cos_mul_pkg: function max_i(int,int); SUM_W/PROD_W width-derivation functions; default width constants.
//   - Sub-module cos_mul_vld_pipe: 3-deep valid shift register with stall/bubble-collapse, producing per-stage load enables.
//   - Top holds the datapath registers, the multiply and the add/sub/saturate logic.
// TESTING  (defaults; SHIFT=0)
//   - a=3, b=100, c=1000, sub=1 -> 3 cycles later out_p=16'd700 (0x02BC), out_ovf=0.
//   - Same sample with c[18]=1 -> out_p=0x82BC; with sub=0 -> out_p=0x0514 (1300).
//   - a=0, b=0, c=20000, sub=1 -> SAT_EN: out_p=0x3FFF, out_ovf=1; no SAT_EN: out_p=0x4E20, out_ovf=1.
//   - 8 back-to-back samples, out_ready=1 -> 8 consecutive out_valid cycles starting cycle 3, in order.
//   - 4 samples in, then out_ready=0 for 5 cycles -> in_ready=0, out_p held stable; all 4 delivered in order once released.
//   - Assert reset_n=0 with 3 samples in flight -> out_valid=0 at once; after release no stale sample appears.

Source files
------------

// File: rtl/cos_mul_pkg.sv
// Shared widths and width-derivation helpers for the cosine multiply-subtract stage.
// Optional feature macro: COS_MUL_SAT_EN (saturating output instead of wrap).
package cos_mul_pkg;

    // Default widths of the original fixed 12x7 stage
    localparam int DEF_A_W   = 7;
    localparam int DEF_B_W   = 12;
    localparam int DEF_C_W   = 19;
    localparam int DEF_P_W   = 16;
    localparam int DEF_SHIFT = 0;

    function automatic int max_i(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Full-precision signed product width
    function automatic int calc_prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Width that holds c_mag +/- (prod >>> shift) without overflow
    function automatic int calc_sum_w(input int a_w, input int b_w, input int c_w, input int shift);
        return max_i(c_w - 1, calc_prod_w(a_w, b_w) - shift) + 1;
    endfunction

endpackage

// File: rtl/cos_mul_vld_pipe.sv
// Three-deep valid shift register for the cosine multiply-subtract pipeline.
// Produces one load enable per stage; empty stages are refilled even when the
// output stage is stalled, so bubbles collapse.
module cos_mul_vld_pipe (
    input  logic clock,
    input  logic reset_n,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic ld1,
    output logic ld2,
    output logic ld3,
    output logic out_valid
);

    // Handshake: a sample moves across an interface on a cycle where both
    // valid and ready are high; valid never waits on ready, and a stage that
    // holds valid data keeps it (and its valid) until it is taken.

    logic v1, v2, v3;
    logic en2, en3;

    // Per-stage move enables: a stage may take new data when it is empty or its content moves on
    always_comb begin
        en3      = ~v3 | out_ready;
        en2      = ~v2 | en3;
        in_ready = en3;
        ld1      = in_valid & in_ready;
        ld2      = v1 & en2;
        ld3      = v2 & en3;
    end

    // Valid bits: set on load, cleared when the content moves on, held otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= ld1 | (v1 & ~en2);
            v2 <= ld2 | (v2 & ~en3);
            v3 <= ld3 | (v3 & ~out_ready);
        end
    end

    assign out_valid = v3;

endmodule

// File: rtl/cos_mul_sub_pipe.sv
// Cosine multiply-subtract stage: p = {c_sign, c_mag -/+ ((a*b) >>> SHIFT)}.
// Three registered stages with valid/ready flow control.
// Optional feature macro: COS_MUL_SAT_EN clamps out-of-range sums instead of wrapping.
module cos_mul_sub_pipe
    import cos_mul_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int C_W   = DEF_C_W,
    parameter int P_W   = DEF_P_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    input  logic [C_W-1:0] in_c,
    input  logic           in_sub,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] out_p,
    output logic           out_ovf
);

    localparam int PROD_W = calc_prod_w(A_W, B_W);
    localparam int SUM_W  = calc_sum_w(A_W, B_W, C_W, SHIFT);
    localparam int CMP_W  = max_i(SUM_W, P_W);
    localparam logic signed [CMP_W-1:0] P_MAX = CMP_W'((2 ** (P_W - 2)) - 1);
    localparam logic signed [CMP_W-1:0] P_MIN = CMP_W'(-(2 ** (P_W - 2)));

    logic ld1, ld2, ld3;

    cos_mul_vld_pipe u_vld (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .ld1       (ld1),
        .ld2       (ld2),
        .ld3       (ld3),
        .out_valid (out_valid)
    );

    // Stage 1 registers
    logic signed [A_W-1:0]    a1;
    logic signed [B_W-1:0]    b1;
    logic signed [C_W-2:0]    cm1;
    logic                     cs1;
    logic                     sub1;
    // Stage 2 registers
    logic signed [PROD_W-1:0] prod2;
    logic signed [C_W-2:0]    cm2;
    logic                     cs2;
    logic                     sub2;

    // Stage 1: capture the accepted sample
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a1   <= '0;
            b1   <= '0;
            cm1  <= '0;
            cs1  <= 1'b0;
            sub1 <= 1'b0;
        end else if (ld1) begin
            a1   <= in_a;
            b1   <= in_b;
            cm1  <= in_c[C_W-2:0];
            cs1  <= in_c[C_W-1];
            sub1 <= in_sub;
        end
    end

    // Stage 2: full-precision signed product, side fields travel alongside
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prod2 <= '0;
            cm2   <= '0;
            cs2   <= 1'b0;
            sub2  <= 1'b0;
        end else if (ld2) begin
            prod2 <= PROD_W'(a1) * PROD_W'(b1);
            cm2   <= cm1;
            cs2   <= cs1;
            sub2  <= sub1;
        end
    end

    logic signed [PROD_W-1:0] prod_sh;
    logic signed [SUM_W-1:0]  prod_ext;
    logic signed [SUM_W-1:0]  c_ext;
    logic signed [SUM_W-1:0]  sum;
    logic signed [CMP_W-1:0]  sum_cmp;
    logic                     ovf;
    logic [P_W-2:0]           data;

    // Exact add/subtract in SUM_W, then range check and wrap or clamp into P_W-1 bits
    always_comb begin
        prod_sh  = prod2 >>> SHIFT;
        prod_ext = SUM_W'(prod_sh);
        c_ext    = SUM_W'(cm2);
        sum      = sub2 ? (c_ext - prod_ext) : (c_ext + prod_ext);
        sum_cmp  = CMP_W'(sum);
        ovf      = (sum_cmp > P_MAX) || (sum_cmp < P_MIN);
`ifdef COS_MUL_SAT_EN
        if (sum_cmp > P_MAX) begin
            data = P_MAX[P_W-2:0];
        end else if (sum_cmp < P_MIN) begin
            data = P_MIN[P_W-2:0];
        end else begin
            data = sum_cmp[P_W-2:0];
        end
`else
        data = sum_cmp[P_W-2:0];
`endif
    end

    // Stage 3: output register, holds its value while stalled or empty
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_p   <= '0;
            out_ovf <= 1'b0;
        end else if (ld3) begin
            out_p   <= {cs2, data};
            out_ovf <= ovf;
        end
    end

endmodule

// File: tb/tb_cos_mul_sub_pipe.sv
// Bench for cos_mul_sub_pipe (default widths, SHIFT=0). Honours COS_MUL_SAT_EN.
module tb_cos_mul_sub_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_a = '0;
  logic [11:0] in_b = '0;
  logic [18:0] in_c = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_p;
  logic        out_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [16:0] prev_val = '0;

  cos_mul_sub_pipe dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_ovf   (out_ovf)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {ovf, p}
  function automatic logic [16:0] model(input logic [6:0] a, input logic [11:0] b,
                                        input logic [18:0] c, input logic s);
    int pa, pb, cm, pr, sm, d;
    logic ov;
    pa = $signed(a);
    pb = $signed(b);
    cm = $signed(c[17:0]);
    pr = pa * pb;
    sm = s ? (cm - pr) : (cm + pr);
    ov = (sm > 16383) || (sm < -16384);
`ifdef COS_MUL_SAT_EN
    d = ov ? ((sm > 0) ? 16383 : -16384) : sm;
`else
    d = sm;
`endif
    return {ov, c[18], d[14:0]};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] a, input logic [11:0] b,
                       input logic [18:0] c, input logic s);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_sub   = s;
  endtask

  task automatic drive_rand(input logic v);
    if ($urandom_range(0, 5) == 0) begin
      drive(v, ($urandom_range(0, 1) != 0) ? 7'h40 : 7'h3F,
               ($urandom_range(0, 1) != 0) ? 12'h800 : 12'h7FF,
               {1'($urandom), (($urandom_range(0, 1) != 0) ? 18'h20000 : 18'h1FFFF)},
               1'($urandom));
    end else begin
      drive(v, 7'($urandom), 12'($urandom), 19'($urandom), 1'($urandom));
    end
  endtask

  // scoreboard: one compare process, runs every cycle out of reset
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_p", {out_ovf, out_p}, prev_val);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", out_valid, 0);
        else check("out_data", {out_ovf, out_p}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_c, in_sub));
      prev_stall = out_valid && !out_ready;
      prev_val   = {out_ovf, out_p};
    end
  end

  task automatic run_literal(input string name, input logic [6:0] a, input logic [11:0] b,
                             input logic [18:0] c, input logic s,
                             input logic [15:0] exp_p, input logic exp_ovf);
    int lat;
    out_ready = 1'b1;
    tick();
    drive(1'b1, a, b, c, s);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_p"}, out_p, exp_p);
    check({name, "_ovf"}, out_ovf, exp_ovf);
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic        ov[16];
    logic [15:0] held;
    int          cnt;

    // reset state
    repeat (3) tick();
    check("reset_out_valid", out_valid, 0);
    check("reset_out_p", out_p, 0);
    check("reset_out_ovf", out_ovf, 0);
    check("reset_in_ready", in_ready, 1);
    reset_n = 1'b1;
    tick();

    // hand-computed points
    run_literal("lit_sub", 7'd3, 12'd100, 19'd1000, 1'b1, 16'h02BC, 1'b0);
    run_literal("lit_sign", 7'd3, 12'd100, 19'h40000 | 19'd1000, 1'b1, 16'h82BC, 1'b0);
    run_literal("lit_add", 7'd3, 12'd100, 19'd1000, 1'b0, 16'h0514, 1'b0);
`ifdef COS_MUL_SAT_EN
    run_literal("lit_range", 7'd0, 12'd0, 19'd20000, 1'b1, 16'h3FFF, 1'b1);
`else
    run_literal("lit_range", 7'd0, 12'd0, 19'd20000, 1'b1, 16'h4E20, 1'b1);
`endif

    // 8 back-to-back samples
    out_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      tick();
      ov[t] = out_valid;
      if (t < 8) drive_rand(1'b1);
      else drive(1'b0, '0, '0, '0, 1'b0);
    end
    cnt = 0;
    for (int t = 0; t < 16; t++) cnt += int'(ov[t]);
    check("b2b_count", cnt, 8);
    check("b2b_first", ov[3], 1);
    check("b2b_before_first", ov[2], 0);
    check("b2b_last", ov[10], 1);
    check("b2b_after_last", ov[11], 0);
    drain("b2b_drain");

    // 4 samples then a 5-cycle stall
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_rand(1'b1);
    end
    tick();
    drive_rand(1'b1);
    out_ready = 1'b0;
    #1;
    check("stall_out_valid", out_valid, 1);
    check("stall_in_ready", in_ready, 0);
    held = out_p;
    repeat (5) begin
      tick();
      check("stall_in_ready_hold", in_ready, 0);
      check("stall_p_hold", out_p, held);
    end
    out_ready = 1'b1;
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    drain("stall_drain");

    // randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      drive_rand($urandom_range(0, 3) != 0);
    end
    drain("random_drain");

    // reset with 3 samples in flight while stalled
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_rand(1'b1);
    end
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    #1;
    check("pre_reset_valid", out_valid, 1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_out_p", out_p, 0);
    check("mid_reset_out_ovf", out_ovf, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    repeat (8) begin
      tick();
      cnt += int'(out_valid);
    end
    check("post_reset_no_stale", cnt, 0);
    run_literal("after_reset", 7'd3, 12'd100, 19'd1000, 1'b0, 16'h0514, 1'b0);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
